vga_fb_dbuf: RTL

- Parametrised, double-buffered VGA framebuffer. Successor to the single-bank framebuffer.
- Two pixel banks:
  - The display reads from the front bank.
  - The CPU writes to and reads from the back bank.
- A CPU-requested swap takes effect only on the next frame_start, so the display never shows a tear.
- Sits between the CPU data bus (MMIO decode drives sel) and the VGA timing controller (supplies h_addr, v_addr, disp_valid, frame_start).

---
 rtl/vga_fb_pkg.sv | 14 +
 rtl/fb_bank.sv | 38 +++
 rtl/vga_fb_dbuf.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the double-buffered VGA framebuffer.
package vga_fb_pkg;

  localparam int unsigned CTRL_SEL_BIT = 20;
  localparam int unsigned SWAP_REQ     = 0;
  localparam int unsigned STAT_FRONT   = 0;
  localparam int unsigned STAT_PEND    = 1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: simple dual-port RAM of two pixels per word, byte-enabled
// write port and synchronous read port with read enable.
module fb_bank #(
  parameter int unsigned WORDS = 153600,
  parameter int unsigned PIX_W = 12,
  parameter int unsigned AW    = 18
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [3:0]        wr_be_i,
  input  logic [2*PIX_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [2*PIX_W-1:0] rd_data_o
);

  localparam int unsigned DW = 2 * PIX_W;

  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] bmask_c;

  // Pixel bit b of halfword h belongs to CPU byte 2h + b/8.
  for (genvar b = 0; b < DW; b++) begin : g_mask
    localparam int unsigned BE = 2 * (b / PIX_W) + (b % PIX_W) / 8;
    assign bmask_c[b] = wr_be_i[BE];
  end

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= (mem[wr_addr_i] & ~bmask_c) | (wr_data_i & bmask_c);
    end
    if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/vga_fb_dbuf.sv
// Double-buffered VGA framebuffer: CPU owns the back bank, display scans the
// front bank, and swaps are deferred to frame_start to avoid tearing.
module vga_fb_dbuf
  import vga_fb_pkg::*;
#(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned PIX_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sel,
  input  logic             we,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      addr,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  output logic             ready,
  input  logic [9:0]       h_addr,
  input  logic [9:0]       v_addr,
  input  logic             disp_valid,
  input  logic             frame_start,
  output logic [PIX_W-1:0] vga_data,
  output logic             front_bank
);

  localparam int unsigned DEPTH  = H_RES * V_RES;
  localparam int unsigned WORDS  = DEPTH / 2;
  localparam int unsigned WORD_W = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned DW     = 2 * PIX_W;

  swap_state_t state_q, state_d;
  logic        front_q, front_d;

  logic             ready_q, rd_valid_q, rd_pix_q, rd_ctrl_q, rd_bank_q;
  logic [1:0]       stat_q, stat_d;
  logic [31:0]      dout_hold_q, dout_live_c;
  logic [IDX_W-1:0] idx_q;
  logic             s1_valid_q, s1_front_q, s2_valid_q, s2_half_q, s2_bank_q;
  logic             s1_valid_d;
  logic [PIX_W-1:0] pix_c;

  logic             is_ctrl_c, in_range_c, wr_pix_c, rd_pix_c, swap_req_c;
  logic [17:0]      cpu_word_c;
  logic [DW-1:0]    brd_data [2];
  logic             unused_c;

  // CPU address decode
  assign is_ctrl_c  = addr[CTRL_SEL_BIT];
  assign cpu_word_c = addr[19:2];
  assign in_range_c = 32'({cpu_word_c, 1'b0}) < DEPTH;
  assign wr_pix_c   = sel & we & ~is_ctrl_c & in_range_c;
  assign rd_pix_c   = sel & ~we & ~is_ctrl_c & in_range_c;
  assign swap_req_c = sel & we & is_ctrl_c & din[SWAP_REQ];
  assign unused_c   = ^{addr[31:21], addr[1:0], din};

  // Read port of the front bank belongs to the display, the back bank's to the CPU.
  for (genvar k = 0; k < 2; k++) begin : g_bank
    logic own_disp_c;
    assign own_disp_c = (front_q == 1'(k));
    fb_bank #(
      .WORDS(WORDS),
      .PIX_W(PIX_W),
      .AW   (WORD_W)
    ) u_bank (
      .clock    (clock),
      .wr_en_i  (wr_pix_c & ~own_disp_c),
      .wr_addr_i(WORD_W'(cpu_word_c)),
      .wr_be_i  (wstrb),
      .wr_data_i({din[16 +: PIX_W], din[0 +: PIX_W]}),
      .rd_en_i  (own_disp_c | rd_pix_c),
      .rd_addr_i(own_disp_c ? WORD_W'(idx_q >> 1) : WORD_W'(cpu_word_c)),
      .rd_data_o(brd_data[k])
    );
  end

  // Swap FSM
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    case (state_q)
      IDLE:    if (swap_req_c) state_d = PENDING;
      PENDING: if (frame_start) begin
        state_d = IDLE;
        front_d = ~front_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stat_d             = '0;
    stat_d[STAT_FRONT] = front_q;
    stat_d[STAT_PEND]  = (state_q == PENDING);
    s1_valid_d         = disp_valid & (32'(h_addr) < H_RES) & (32'(v_addr) < V_RES);
  end

  always_comb begin
    dout_live_c = '0;
    if (rd_pix_q) begin
      dout_live_c[0 +: PIX_W]  = brd_data[rd_bank_q][PIX_W-1:0];
      dout_live_c[16 +: PIX_W] = brd_data[rd_bank_q][DW-1:PIX_W];
    end else if (rd_ctrl_q) begin
      dout_live_c[1:0] = stat_q;
    end
  end

  assign pix_c = s2_half_q ? brd_data[s2_bank_q][DW-1:PIX_W] : brd_data[s2_bank_q][PIX_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      front_q     <= 1'b0;
      ready_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_pix_q    <= 1'b0;
      rd_ctrl_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      stat_q      <= '0;
      dout_hold_q <= '0;
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_front_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_half_q   <= 1'b0;
      s2_bank_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      front_q    <= front_d;
      ready_q    <= sel;
      rd_valid_q <= sel & ~we;
      if (sel & ~we) begin
        rd_pix_q  <= rd_pix_c;
        rd_ctrl_q <= is_ctrl_c;
        rd_bank_q <= ~front_q;
        stat_q    <= stat_d;
      end
      if (rd_valid_q) dout_hold_q <= dout_live_c;
      // Stage 1 samples the bank that is front from this edge on.
      idx_q      <= IDX_W'(32'(v_addr) * H_RES + 32'(h_addr));
      s1_valid_q <= s1_valid_d;
      s1_front_q <= front_d;
      s2_valid_q <= s1_valid_q;
      s2_half_q  <= idx_q[0];
      s2_bank_q  <= s1_front_q;
    end
  end

  assign dout       = rd_valid_q ? dout_live_c : dout_hold_q;
  assign ready      = ready_q;
  assign vga_data   = s2_valid_q ? pix_c : '0;
  assign front_bank = front_q;

endmodule
